// File: rtl/mem_pkg.sv
// Shared types and helpers for the banked data memory front end.
package mem_pkg;

   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned XLEN      = 32;

   typedef enum logic [1:0] {
      SIZE_B    = 2'b00,
      SIZE_H    = 2'b01,
      SIZE_W    = 2'b10,
      SIZE_RSVD = 2'b11
   } mem_size_e;

   typedef struct packed {
      logic            fault;
      logic [XLEN-1:0] rdata;
   } mem_rsp_t;

   // Reserved size reports zero bytes; callers fault it separately.
   function automatic logic [2:0] size_bytes(input mem_size_e size);
      case (size)
         SIZE_B:  return 3'd1;
         SIZE_H:  return 3'd2;
         SIZE_W:  return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/byte_lane_steer.sv
// Combinational byte steering between a request and the four byte-wide banks.
module byte_lane_steer
   import mem_pkg::*;
#(
   parameter int unsigned AW = 12
) (
   input  logic [1:0]                           lane_off,
   input  logic [AW-1:0]                        word_idx,
   input  logic [2:0]                           nbytes,
   input  logic [XLEN-1:0]                      wdata,
   input  logic [NUM_LANES-1:0][BYTE_W-1:0]     bank_rdata,
   output logic [NUM_LANES-1:0]                 lane_act,
   output logic [NUM_LANES-1:0][AW-1:0]         lane_word,
   output logic [NUM_LANES-1:0][BYTE_W-1:0]     lane_wdata,
   output logic [XLEN-1:0]                      rd_raw
);

   logic [NUM_LANES-1:0][1:0] lane_k;

   // Lane j carries request byte k = (j - offset) mod 4; lanes below the offset wrap to the next word.
   always_comb begin
      lane_k     = '0;
      lane_act   = '0;
      lane_word  = '0;
      lane_wdata = '0;
      for (int j = 0; j < NUM_LANES; j++) begin
         lane_k[j]     = 2'(j) - lane_off;
         lane_act[j]   = {1'b0, lane_k[j]} < nbytes;
         lane_word[j]  = word_idx + AW'(2'(j) < lane_off);
         lane_wdata[j] = wdata[{lane_k[j], 3'b000} +: BYTE_W];
      end
   end

   // Rotate bank bytes back into request byte order.
   always_comb begin
      rd_raw = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         rd_raw[BYTE_W*k +: BYTE_W] = bank_rdata[2'(2'(k) + lane_off)];
      end
   end

endmodule

// File: rtl/banked_data_mem_ctrl.sv
// RV32E data memory load/store front end: handshake, fault check, lane steering and response register.
module banked_data_mem_ctrl
   import mem_pkg::*;
#(
   parameter  int unsigned DATA_DEPTH = 4096,
   localparam int unsigned AW         = $clog2(DATA_DEPTH)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic                              req_we,
   input  logic [31:0]                       req_addr,
   input  logic [1:0]                        req_size,
   input  logic                              req_unsigned,
   input  logic [31:0]                       req_wdata,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [31:0]                       rsp_rdata,
   output logic                              rsp_fault,
   output logic [NUM_LANES-1:0]              bank_we,
   output logic [NUM_LANES-1:0][AW-1:0]      bank_addr_a,
   output logic [NUM_LANES-1:0][BYTE_W-1:0]  bank_wdata,
   output logic [NUM_LANES-1:0][AW-1:0]      bank_addr_b,
   input  logic [NUM_LANES-1:0][BYTE_W-1:0]  bank_rdata
);

   localparam logic [32:0] MEM_BYTES = 33'(NUM_LANES * DATA_DEPTH);

   mem_size_e                           size;
   logic [2:0]                          nbytes;
   logic [32:0]                         last_byte;
   logic                                fault_c;
   logic                                accept_c;
   logic [NUM_LANES-1:0]                lane_act;
   logic [NUM_LANES-1:0][AW-1:0]        lane_word;
   logic [NUM_LANES-1:0][BYTE_W-1:0]    lane_wdata;
   logic [XLEN-1:0]                     rd_raw;
   logic [XLEN-1:0]                     rd_ext;
   logic                                rsp_valid_d, rsp_valid_q;
   mem_rsp_t                            rsp_d, rsp_q;

   assign size      = mem_size_e'(req_size);
   assign nbytes    = size_bytes(size);
   // 33-bit sum so accesses wrapping past 0xFFFFFFFF are caught as out of range.
   assign last_byte = {1'b0, req_addr} + 33'(nbytes) - 33'd1;
   assign fault_c   = (size == SIZE_RSVD) || (last_byte >= MEM_BYTES);

   assign req_ready = rst_n && (!rsp_valid_q || rsp_ready);
   assign accept_c  = req_valid && req_ready;

   byte_lane_steer #(
      .AW (AW)
   ) u_steer (
      .lane_off   (req_addr[1:0]),
      .word_idx   (req_addr[AW+1:2]),
      .nbytes     (nbytes),
      .wdata      (req_wdata),
      .bank_rdata (bank_rdata),
      .lane_act   (lane_act),
      .lane_word  (lane_word),
      .lane_wdata (lane_wdata),
      .rd_raw     (rd_raw)
   );

   assign bank_addr_a = lane_word;
   assign bank_addr_b = lane_word;
   assign bank_wdata  = lane_wdata;
   assign bank_we     = (accept_c && req_we && !fault_c) ? lane_act : '0;

   always_comb begin
      rd_ext = '0;
      case (size)
         SIZE_B:  rd_ext = {{24{rd_raw[7]  & ~req_unsigned}}, rd_raw[7:0]};
         SIZE_H:  rd_ext = {{16{rd_raw[15] & ~req_unsigned}}, rd_raw[15:0]};
         SIZE_W:  rd_ext = rd_raw;
         default: rd_ext = '0;
      endcase
   end

   // One-deep response slot; a new acceptance overwrites a response consumed in the same cycle.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_d       = rsp_q;
      if (accept_c) begin
         rsp_valid_d = 1'b1;
         rsp_d.fault = fault_c;
         rsp_d.rdata = (req_we || fault_c) ? '0 : rd_ext;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_q.rdata;
   assign rsp_fault = rsp_q.fault;

endmodule

// File: tb/tb_banked_data_mem_ctrl.sv
// Directed bench for banked_data_mem_ctrl with a four-bank byte memory model.
module tb_banked_data_mem_ctrl;

   localparam int unsigned DEPTH = 4096;
   localparam int unsigned AW    = 12;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid, req_ready, req_we, req_unsigned;
   logic [31:0]       req_addr, req_wdata;
   logic [1:0]        req_size;
   logic              rsp_valid, rsp_ready, rsp_fault;
   logic [31:0]       rsp_rdata;
   logic [3:0]        bank_we;
   logic [3:0][AW-1:0] bank_addr_a, bank_addr_b;
   logic [3:0][7:0]   bank_wdata, bank_rdata;

   logic [7:0]        mem [4][DEPTH];
   int                n_pass  = 0;
   int                n_total = 0;
   int                bad_we  = 0;
   logic [3:0]        last_we;
   logic [3:0][AW-1:0] last_addr_a, last_addr_b;
   logic [3:0][7:0]   last_wdata;

   banked_data_mem_ctrl #(.DATA_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_fault    (rsp_fault),
      .bank_we      (bank_we),
      .bank_addr_a  (bank_addr_a),
      .bank_wdata   (bank_wdata),
      .bank_addr_b  (bank_addr_b),
      .bank_rdata   (bank_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int j = 0; j < 4; j++)
         if (bank_we[j]) mem[j][bank_addr_a[j]] <= bank_wdata[j];
      if (!rst_n && bank_we != 4'b0) bad_we <= bad_we + 1;
   end

   always_comb begin
      for (int j = 0; j < 4; j++) bank_rdata[j] = mem[j][bank_addr_b[j]];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
   endtask

   task automatic chk_rsp(input string tag, input logic [31:0] exp_d, input logic exp_f);
      chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_rdata"}, rsp_rdata, exp_d);
      chk({tag, "_fault"}, 32'(rsp_fault), 32'(exp_f));
   endtask

   task automatic set_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wd);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wd;
   endtask

   // Presents one request, waits (bounded) for acceptance, returns 1 time unit after the accept edge.
   task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd);
      int guard = 0;
      set_req(we, addr, size, uns, wd);
      #1;
      while (!req_ready && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      chk("accept_wait", 32'(req_ready), 32'd1);
      last_we = bank_we; last_addr_a = bank_addr_a; last_addr_b = bank_addr_b; last_wdata = bank_wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; rsp_ready = 1'b1;
      set_req(1'b1, 32'h100, 2'b10, 1'b0, 32'hA5A5A5A5);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
      chk("rst_bank_we", 32'(bank_we), 32'd0);
      req_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      idle();
      chk("post_rst_ready", 32'(req_ready), 32'd1);

      // aligned word
      send(1'b1, 32'h100, 2'b10, 1'b0, 32'hDEADBEEF);
      chk("sw_al_we", 32'(last_we), 32'hF);
      chk("sw_al_addr0", 32'(last_addr_a[0]), 32'h40);
      chk("sw_al_addr3", 32'(last_addr_a[3]), 32'h40);
      chk("sw_al_wdata", last_wdata, 32'hDEADBEEF);
      chk_rsp("sw_al", 32'd0, 1'b0);
      send(1'b0, 32'h100, 2'b10, 1'b0, 32'd0);
      chk("lw_al_we", 32'(last_we), 32'd0);
      chk_rsp("lw_al", 32'hDEADBEEF, 1'b0);

      // misaligned word
      send(1'b1, 32'h103, 2'b10, 1'b0, 32'h11223344);
      chk("sw_mis_we", 32'(last_we), 32'hF);
      chk("sw_mis_wdata", last_wdata, 32'h44112233);
      chk("sw_mis_addr3", 32'(last_addr_a[3]), 32'h40);
      chk("sw_mis_addr0", 32'(last_addr_a[0]), 32'h41);
      chk("sw_mis_addrb2", 32'(last_addr_b[2]), 32'h41);
      chk_rsp("sw_mis", 32'd0, 1'b0);
      send(1'b0, 32'h103, 2'b10, 1'b0, 32'd0);
      chk_rsp("lw_mis", 32'h11223344, 1'b0);

      // sign / zero extension
      send(1'b1, 32'h200, 2'b00, 1'b0, 32'hFFFFFF80);
      chk("sb_we", 32'(last_we), 32'h1);
      send(1'b1, 32'h202, 2'b01, 1'b0, 32'h00008001);
      chk("sh_we", 32'(last_we), 32'hC);
      send(1'b0, 32'h200, 2'b00, 1'b0, 32'd0);
      chk_rsp("lb", 32'hFFFFFF80, 1'b0);
      send(1'b0, 32'h200, 2'b00, 1'b1, 32'd0);
      chk_rsp("lbu", 32'h00000080, 1'b0);
      send(1'b0, 32'h202, 2'b01, 1'b0, 32'd0);
      chk_rsp("lh", 32'hFFFF8001, 1'b0);
      send(1'b0, 32'h202, 2'b01, 1'b1, 32'd0);
      chk_rsp("lhu", 32'h00008001, 1'b0);

      // faults and range boundary
      send(1'b0, 32'h3FFD, 2'b10, 1'b0, 32'd0);
      chk_rsp("lw_oob", 32'd0, 1'b1);
      send(1'b0, 32'h0, 2'b11, 1'b0, 32'd0);
      chk_rsp("rsvd", 32'd0, 1'b1);
      send(1'b1, 32'hFFFFFFFF, 2'b01, 1'b0, 32'h0000FFFF);
      chk("sh_wrap_we", 32'(last_we), 32'd0);
      chk_rsp("sh_wrap", 32'd0, 1'b1);
      send(1'b1, 32'h3FFD, 2'b10, 1'b0, 32'h12345678);
      chk("sw_oob_we", 32'(last_we), 32'd0);
      chk_rsp("sw_oob", 32'd0, 1'b1);
      send(1'b1, 32'h3FFF, 2'b00, 1'b0, 32'h0000007F);
      chk("sb_top_we", 32'(last_we), 32'h8);
      chk_rsp("sb_top", 32'd0, 1'b0);
      send(1'b0, 32'h3FFF, 2'b00, 1'b0, 32'd0);
      chk_rsp("lb_top", 32'h0000007F, 1'b0);
      send(1'b0, 32'h3FFC, 2'b10, 1'b0, 32'd0);
      chk("lw_last_fault", 32'(rsp_fault), 32'd0);

      // reset while a response is stalled, with a store presented during reset
      idle();
      rsp_ready = 1'b0;
      send(1'b0, 32'h100, 2'b10, 1'b0, 32'd0);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      #3;
      rst_n = 1'b0;
      set_req(1'b1, 32'h100, 2'b10, 1'b0, 32'h0);
      #1;
      chk("midrst_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_rdata", rsp_rdata, 32'd0);
      chk("midrst_ready", 32'(req_ready), 32'd0);
      chk("midrst_we", 32'(bank_we), 32'd0);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; rst_n = 1'b1; rsp_ready = 1'b1;
      #1;
      chk("midrst_post_ready", 32'(req_ready), 32'd1);
      send(1'b0, 32'h100, 2'b10, 1'b0, 32'd0);
      chk_rsp("midrst_mem", 32'h44ADBEEF, 1'b0);

      // backpressure across three loads
      idle();
      rsp_ready = 1'b0;
      send(1'b0, 32'h100, 2'b10, 1'b0, 32'd0);
      chk_rsp("bp1", 32'h44ADBEEF, 1'b0);
      set_req(1'b0, 32'h200, 2'b00, 1'b0, 32'd0);
      #1;
      chk("bp_ready_a", 32'(req_ready), 32'd0);
      idle();
      chk("bp_ready_b", 32'(req_ready), 32'd0);
      chk_rsp("bp1_hold", 32'h44ADBEEF, 1'b0);
      rsp_ready = 1'b1;
      #1;
      chk("bp_ready_c", 32'(req_ready), 32'd1);
      idle();
      chk_rsp("bp2", 32'hFFFFFF80, 1'b0);
      set_req(1'b0, 32'h202, 2'b01, 1'b0, 32'd0);
      idle();
      chk_rsp("bp3", 32'hFFFF8001, 1'b0);
      req_valid = 1'b0;
      idle();
      chk("bp_drain", 32'(rsp_valid), 32'd0);

      chk("no_reset_we", 32'(bad_we), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
